// File: rtl/aes_lookup_pkg.sv
// AES lookup package: mode enum, forward/inverse S-box tables and
// GF(2^8) helpers (modulus 0x11b) shared by the lookup pipeline.
package aes_lookup_pkg;

    typedef enum logic [1:0] {
        FWD_S = 2'd0,
        FWD_T = 2'd1,
        INV_S = 2'd2,
        INV_T = 2'd3
    } lookup_mode_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (2, 3, 9, b, d, e in practice)
    // as an xor of the selected xtime powers.
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (c[0] ? a  : 8'h00) ^ (c[1] ? a2 : 8'h00) ^
               (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
    endfunction

endpackage

// File: rtl/aes_byte_lookup.sv
// Registered single-byte lookup: S/Si substitution and T-table coefficients.
// Ports: clk, rst_n, en (load), byte_in, mode -> coef {c0,c1,c2,c3}.
module aes_byte_lookup
    import aes_lookup_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  byte_in,
    input  logic [1:0]  mode,
    output logic [31:0] coef
);

    logic [7:0]  s;
    logic [7:0]  si;
    logic [31:0] coef_d;
    logic [31:0] coef_q;

    always_comb begin
        s      = SBOX[byte_in];
        si     = INV_SBOX[byte_in];
        coef_d = '0;
        unique case (lookup_mode_t'(mode))
            FWD_S:   coef_d = {s, 24'h0};
            FWD_T:   coef_d = {gmul(s, 4'h2), s, s, gmul(s, 4'h3)};
            INV_S:   coef_d = {si, 24'h0};
            INV_T:   coef_d = {gmul(si, 4'he), gmul(si, 4'h9),
                               gmul(si, 4'hd), gmul(si, 4'hb)};
            default: coef_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_q <= '0;
        end else if (en) begin
            coef_q <= coef_d;
        end
    end

    assign coef = coef_q;

endmodule

// File: rtl/aes_lookup_pipe.sv
// Multi-lane pipelined AES S-box / T-table unit with valid/ready flow.
// Ports: in_* (valid/ready/mode/tag/data), out_* (valid/ready/mode/tag/data).
module aes_lookup_pipe
    import aes_lookup_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIPE  = 1,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [32*LANES-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_mode,
    output logic [TAG_W-1:0]     out_tag,
    output logic [128*LANES-1:0] out_data
);

    localparam int DW = 128 * LANES;

    logic [PIPE:0]      en;
    logic [PIPE:0]      vld_d;
    logic [PIPE:0]      vld_q;
    logic [1:0]         mode_d [PIPE+1];
    logic [1:0]         mode_q [PIPE+1];
    logic [TAG_W-1:0]   tag_d  [PIPE+1];
    logic [TAG_W-1:0]   tag_q  [PIPE+1];
    logic               ld0;
    logic [31:0]        coef   [4*LANES];
    logic [DW-1:0]      asm_data;

    // Stage 0 only captures new data on a real handshake; bubbles
    // just clear the valid and leave the lookup registers alone.
    assign ld0 = en[0] && in_valid;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar b = 0; b < 4; b++) begin : g_byte
            aes_byte_lookup u_lut (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (ld0),
                .byte_in (in_data[32*l + 8*(3-b) +: 8]),
                .mode    (in_mode),
                .coef    (coef[4*l + b])
            );
        end
    end

    // Ready ripples back from the consumer through empty stages.
    always_comb begin
        logic e;
        e        = !vld_q[PIPE] || out_ready;
        en       = '0;
        en[PIPE] = e;
        for (int k = PIPE - 1; k >= 0; k--) begin
            e     = !vld_q[k] || e;
            en[k] = e;
        end
    end

    // p_i is coefficient word i rotated right by 8*i bits; S modes
    // instead gather the top byte of each word into p0.
    always_comb begin
        logic is_s;
        is_s     = (mode_q[0] == FWD_S) || (mode_q[0] == INV_S);
        asm_data = '0;
        for (int l = 0; l < LANES; l++) begin
            if (is_s) begin
                asm_data[128*l +: 128] = {coef[4*l][31:24],
                                          coef[4*l+1][31:24],
                                          coef[4*l+2][31:24],
                                          coef[4*l+3][31:24],
                                          96'h0};
            end else begin
                asm_data[128*l +: 128] = {
                    coef[4*l],
                    coef[4*l+1][7:0],  coef[4*l+1][31:8],
                    coef[4*l+2][15:0], coef[4*l+2][31:16],
                    coef[4*l+3][23:0], coef[4*l+3][31:24]
                };
            end
        end
    end

    always_comb begin
        vld_d  = vld_q;
        mode_d = mode_q;
        tag_d  = tag_q;
        if (en[0]) begin
            vld_d[0] = in_valid;
        end
        if (ld0) begin
            mode_d[0] = in_mode;
            tag_d[0]  = in_tag;
        end
        for (int k = 1; k <= PIPE; k++) begin
            if (en[k]) begin
                vld_d[k]  = vld_q[k-1];
                mode_d[k] = mode_q[k-1];
                tag_d[k]  = tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k <= PIPE; k++) begin
                mode_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            tag_q  <= tag_d;
        end
    end

    if (PIPE > 0) begin : g_pipe
        // data_q[j] holds stage j+1.
        logic [DW-1:0] data_d [PIPE];
        logic [DW-1:0] data_q [PIPE];

        always_comb begin
            data_d = data_q;
            if (en[1]) begin
                data_d[0] = asm_data;
            end
            for (int k = 1; k < PIPE; k++) begin
                if (en[k+1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < PIPE; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                data_q <= data_d;
            end
        end

        assign out_data = data_q[PIPE-1];
    end else begin : g_nopipe
        assign out_data = asm_data;
    end

    assign in_ready  = en[0];
    assign out_valid = vld_q[PIPE];
    assign out_mode  = mode_q[PIPE];
    assign out_tag   = tag_q[PIPE];

endmodule

// File: tb/tb_aes_lookup_pipe.sv
// Self-checking bench for aes_lookup_pipe: directed AES vectors, bubble,
// random flow-control scoreboard and mid-flight reset.
module tb_aes_lookup_pipe;

    localparam int LANES = 4;
    localparam int PIPE  = 1;
    localparam int TAG_W = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_mode;
    logic [TAG_W-1:0]     in_tag;
    logic [32*LANES-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_mode;
    logic [TAG_W-1:0]     out_tag;
    logic [128*LANES-1:0] out_data;

    aes_lookup_pipe #(
        .LANES (LANES),
        .PIPE  (PIPE),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_tag   (out_tag),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gm(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = 8'((x << n) | (x >> (8 - n)));
        return r;
    endfunction

    // S-box derived from its definition: GF inverse + affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                ^ rotl(inv, 4) ^ 8'h63;
            sb[a]  = s;
            isb[s] = 8'(a);
        end
    endtask

    function automatic logic [511:0] model(input logic [1:0] m,
                                           input logic [127:0] d);
        logic [511:0] r;
        logic [7:0]   x0, x1, x2, x3;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            x0 = d[32*l+24 +: 8];
            x1 = d[32*l+16 +: 8];
            x2 = d[32*l+8  +: 8];
            x3 = d[32*l    +: 8];
            case (m)
                2'd0: r[128*l +: 128] = {sb[x0], sb[x1], sb[x2], sb[x3],
                                         96'h0};
                2'd2: r[128*l +: 128] = {isb[x0], isb[x1], isb[x2],
                                         isb[x3], 96'h0};
                2'd1: begin
                    x0 = sb[x0]; x1 = sb[x1]; x2 = sb[x2]; x3 = sb[x3];
                    r[128*l +: 128] = {
                        gm(x0, 2), x0, x0, gm(x0, 3),
                        gm(x1, 3), gm(x1, 2), x1, x1,
                        x2, gm(x2, 3), gm(x2, 2), x2,
                        x3, x3, gm(x3, 3), gm(x3, 2)};
                end
                default: begin
                    x0 = isb[x0]; x1 = isb[x1]; x2 = isb[x2]; x3 = isb[x3];
                    r[128*l +: 128] = {
                        gm(x0, 14), gm(x0, 9), gm(x0, 13), gm(x0, 11),
                        gm(x1, 11), gm(x1, 14), gm(x1, 9), gm(x1, 13),
                        gm(x2, 13), gm(x2, 11), gm(x2, 14), gm(x2, 9),
                        gm(x3, 9), gm(x3, 13), gm(x3, 11), gm(x3, 14)};
                end
            endcase
        end
        return r;
    endfunction

    task automatic run_one(input logic [1:0] m, input logic [31:0] w,
                           input logic [3:0] t, input logic [127:0] exp,
                           input string name);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        in_mode   = m;
        in_tag    = t;
        in_data   = {4{w}};
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 512'(lat), 512'(1 + PIPE));
        chk({name, "_data"}, out_data, {4{exp}});
        chk({name, "_meta"}, 512'({out_mode, out_tag}), 512'({m, t}));
    endtask

    typedef struct packed {
        logic [1:0]   m;
        logic [3:0]   t;
        logic [127:0] d;
    } beat_t;

    beat_t        q[$];
    beat_t        bt;
    int           sent;
    int           recvd;
    int           cyc;
    int           ghosts;
    logic         held_v;
    logic [511:0] held_data;
    logic [5:0]   held_meta;
    logic [7:0]   iv_pat;
    logic [7:0]   ov_seq;
    logic [7:0]   ir_seq;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = '0;
        in_tag    = '0;
        in_data   = '0;
        out_ready = 1'b0;
        build_sbox();

        #12;
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_data", out_data, 512'(0));
        chk("rst_out_meta", 512'({out_mode, out_tag}), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 512'(in_ready), 512'(1));

        run_one(2'd1, 32'h00000000, 4'h1,
                128'hc66363a5_a5c66363_63a5c663_6363a5c6, "fwd_t");
        run_one(2'd3, 32'h00000000, 4'h2,
                128'h51f4a750_5051f4a7_a75051f4_f4a75051, "inv_t");
        run_one(2'd0, 32'h00015363, 4'h3,
                128'h637cedfb_00000000_00000000_00000000, "fwd_s");
        run_one(2'd2, 32'h637cedfb, 4'h4,
                128'h00015363_00000000_00000000_00000000, "inv_s");

        repeat (3) @(negedge clk);
        iv_pat = 8'b0000_1011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid  = iv_pat[i];
            in_mode   = 2'd1;
            in_tag    = 4'(i);
            in_data   = '0;
            out_ready = 1'b1;
            #1;
            ov_seq[i] = out_valid;
            ir_seq[i] = in_ready;
        end
        in_valid = 1'b0;
        chk("bubble_out_valid", 512'(ov_seq), 512'(8'b0010_1100));
        chk("stream_in_ready", 512'(ir_seq), 512'(8'hff));
        repeat (3) @(negedge clk);

        sent   = 0;
        recvd  = 0;
        cyc    = 0;
        held_v = 1'b0;
        while ((sent < 64 || recvd < 64) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            in_valid = (sent < 64) && ($urandom_range(0, 3) != 0);
            if (in_valid) begin
                in_mode = 2'($urandom);
                in_tag  = 4'($urandom);
                in_data = {$urandom, $urandom, $urandom, $urandom};
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (held_v) begin
                chk("stall_hold_data", out_data, held_data);
                chk("stall_hold_meta", 512'({out_valid, out_mode, out_tag}),
                    512'({1'b1, held_meta}));
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 512'(q.size() != 0), 512'(1));
                if (q.size() != 0) begin
                    bt = q.pop_front();
                    chk("rand_data", out_data, model(bt.m, bt.d));
                    chk("rand_meta", 512'({out_mode, out_tag}),
                        512'({bt.m, bt.t}));
                end
                recvd++;
            end
            held_v    = out_valid && !out_ready;
            held_data = out_data;
            held_meta = {out_mode, out_tag};
            if (in_valid && in_ready) begin
                q.push_back('{m: in_mode, t: in_tag, d: in_data});
                sent++;
            end
        end
        in_valid = 1'b0;
        chk("rand_sent", 512'(sent), 512'(64));
        chk("rand_recvd", 512'(recvd), 512'(64));
        chk("rand_sb_empty", 512'(q.size()), 512'(0));

        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'd1;
            in_tag   = 4'(9 + i);
            in_data  = {4{32'h01020304}};
            if (i == 2) begin
                #1;
                chk("full_in_ready", 512'(in_ready), 512'(0));
                chk("full_out_valid", 512'(out_valid), 512'(1));
            end else begin
                @(negedge clk);
            end
        end
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 512'(out_valid), 512'(0));
        chk("midrst_out_data", out_data, 512'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 512'(in_ready), 512'(1));
        ghosts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) ghosts++;
        end
        chk("midrst_no_ghost", 512'(ghosts), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_lookup_pipe.md
# aes_lookup_pipe

Multi-lane, pipelined AES byte-substitution and round-table unit with valid/ready flow control. It serves the forward and inverse cipher datapaths and key expansion. Per beat it accepts `LANES` 32-bit state words and produces, for each word, the four rotated T-table words (forward or inverse) or a plain byte substitution. Throughput is one beat per clock when the consumer does not stall.

## Interface
Parameters:
- `LANES`, 4: 32-bit words per beat (1..8).
- `PIPE`, 1: extra register stages after the lookup stage (0..4).
- `TAG_W`, 4: width of the sideband tag carried with each beat.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: unit accepts the beat this cycle.
- `in_mode`, in, 2: 0 FWD_S, 1 FWD_T, 2 INV_S, 3 INV_T.
- `in_tag`, in, `TAG_W`: opaque sideband, returned unchanged.
- `in_data`, in, 32·`LANES`: lane k in bits [32k+31:32k]. Byte b0 is the MSB.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_mode`, out, 2: mode of the result beat.
- `out_tag`, out, `TAG_W`: tag of the result beat.
- `out_data`, out, 128·`LANES`: lane k = {p0,p1,p2,p3} in bits [128k+127:128k].

## Operation
- Per lane: the word splits into bytes b0..b3. S = forward S-box, Si = inverse S-box. Products are in GF(2^8) with modulus 0x11b.
- FWD_T:
  - p0={2S(b0),S(b0),S(b0),3S(b0)}
  - p1={3S(b1),2S(b1),S(b1),S(b1)}
  - p2={S(b2),3S(b2),2S(b2),S(b2)}
  - p3={S(b3),S(b3),3S(b3),2S(b3)}
- INV_T, with x = Si(bi):
  - p0={e·x,9·x,d·x,b·x}
  - p1={b·x,e·x,9·x,d·x}
  - p2={d·x,b·x,e·x,9·x}
  - p3={9·x,d·x,b·x,e·x}
- FWD_S: p0={S(b0),S(b1),S(b2),S(b3)}, and p1=p2=p3=0.
- INV_S: the same as FWD_S, with Si in place of S.
- Mode and tag travel with the beat. Lanes are independent and all use the beat's mode.
- Pipeline: stage 0 is the registered lookup. It is followed by `PIPE` plain register stages, each with a valid bit.
- Per-stage advance: enable_k = !valid_k || enable_(k+1). For the last stage: enable = !out_valid || out_ready.
- `in_ready` = enable_0. This is a combinational path from `out_ready`, and that path is intentional.
- Stalls collapse bubbles. A stage holds its data and valid while its enable is low.
- No beat is dropped or duplicated. Beats exit in acceptance order.

## Timing
- Latency from input handshake to `out_valid` = 1 + `PIPE` cycles, with no stalls.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Reset values: all stage valids are 0, so `out_valid`=0. `out_data`, `out_mode` and `out_tag` are 0. `in_ready`=1 as soon as reset deasserts.
- Reset asserted mid-operation: all in-flight beats are discarded immediately (async). No output appears afterward for them.
- Full pipe with `out_ready`=0: `in_ready`=0 and all registers hold. The output must be stable while `out_valid` && !`out_ready`.
- Simultaneous exit and entry with a full pipe and `out_ready`=1: the pipe shifts, `in_ready`=1, and no bubble is inserted.
- `in_valid`=0 while the pipe shifts: a bubble propagates, and `out_valid` drops for exactly one cycle when it reaches the output.

## Structure
- Package `aes_lookup_pkg`:
  - 256-entry constant arrays `SBOX` and `INV_SBOX`.
  - Functions `xtime` and `gmul(a, const)` for the constants 2, 3, 9, b, d, e.
  - Enum `lookup_mode_t`.
- Sub-module `aes_byte_lookup`: clk, rst_n, en, 8-bit byte, 2-bit mode in; registered 32-bit coefficient word out.
  - Coefficient order for T modes: forward {2S,S,S,3S}, inverse {e,9,d,b}.
  - Coefficient word for S modes: {S or Si, 0, 0, 0}.
- The top level instantiates 4·`LANES` copies of `aes_byte_lookup`.
- The top level then does the p0..p3 rotation/assembly as wiring, carries the stage valids, and carries the mode/tag pipeline.

## Test plan
- FWD_T, lane0=0x00000000 → p0=0xc66363a5, p1=0xa5c66363, p2=0x63a5c663, p3=0x6363a5c6, after 1+`PIPE` cycles.
- INV_T, lane0=0x00000000 → p0=0x51f4a750, p1=0x5051f4a7, p2=0xa75051f4, p3=0xf4a75051.
- FWD_S, lane0=0x00015363 → p0=0x637ced fb, p1=p2=p3=0.
- INV_S, lane0=0x637cedfb → p0=0x00015363, p1=p2=p3=0.
- Back-to-back 64 random beats with random `out_ready` (50%) and random `in_valid` gaps:
  - output sequence, tags and modes match a scoreboard model;
  - output is stable during stalls;
  - no loss or duplication.
- Assert `rst_n` low with 3 beats in flight:
  - `out_valid`=0 immediately;
  - `out_data`=0;
  - after release, `in_ready`=1 and none of the 3 beats appear.
